// File: rtl/lcd_uart_pkg.sv
// Purpose: shared constants, frame FSM encoding and command check for the LCD status decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_uart_pkg;

  localparam logic [7:0] FRAME_SOF    = 8'hA5;
  localparam int         CMD_RSVD_MSB = 7;
  localparam int         CMD_RSVD_LSB = 5;
  localparam int         MESS_W       = 3;
  localparam int         ROLE_W       = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_CHK
  } frame_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // A command is accepted only when the checksum matches and the reserved bits are clear.
  function automatic logic frame_cmd_ok(input logic [7:0] cmd, input logic [7:0] chk);
    return (chk == (FRAME_SOF ^ cmd)) && (cmd[CMD_RSVD_MSB:CMD_RSVD_LSB] == '0);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Purpose: 8N1 UART byte receiver (synchronizer, bit timer, shift register).
// Latency: rx_valid/rx_ferr pulse at the stop-bit centre, ~9.5 bit times after the start edge.
// Backpressure: none; each byte is offered for exactly one cycle.
// Ports: clk, rst (sync, active-high), rxd (async line, idle high),
//        rx_valid + rx_byte (good stop bit), rx_ferr (stop bit low).
module uart_rx_byte
  import lcd_uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic             rxd_meta, rxd_sync, rxd_prev;
  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    rx_valid    = 1'b0;
    rx_ferr     = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (rxd_prev && !rxd_sync) state_nxt = RX_START;
      end
      RX_START: begin
        // Re-check at mid start bit; a line already back high was a glitch.
        if (cnt == HALF_LAST) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rxd_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          shift_nxt   = {rxd_sync, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = RX_IDLE;
          rx_valid  = rxd_sync;
          rx_ferr   = !rxd_sync;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign rx_byte = shift;

endmodule

// File: rtl/lcd_status_decoder.sv
// Purpose: decode UART status frames (A5, CMD, CHK) into LCD message/role selects.
// Latency: outputs load and oUPDATE pulses one cycle after the CHK byte is received.
// Backpressure: none; bytes are consumed as they arrive, errors only bump oERR_CNT.
// Ports: iCLK, iRST (sync, active-high), iRXD (UART line), oMESS, oIS_SERVER,
//        oUPDATE (load strobe), oERR_CNT (saturating error count).
module lcd_status_decoder
  import lcd_uart_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iRXD,
  output logic [MESS_W-1:0] oMESS,
  output logic [ROLE_W-1:0] oIS_SERVER,
  output logic              oUPDATE,
  output logic [7:0]        oERR_CNT
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  logic         rx_valid, rx_ferr;
  logic [7:0]   rx_byte;

  frame_state_t state, state_nxt;
  logic [7:0]   cmd_q, cmd_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic         load, err;

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk      (iCLK),
    .rst      (iRST),
    .rxd      (iRXD),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_ferr  (rx_ferr)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= S_IDLE;
      cmd_q      <= '0;
      gap_cnt    <= '0;
      oMESS      <= '0;
      oIS_SERVER <= '0;
      oUPDATE    <= 1'b0;
      oERR_CNT   <= '0;
    end else begin
      state   <= state_nxt;
      cmd_q   <= cmd_nxt;
      gap_cnt <= gap_nxt;
      oUPDATE <= load;
      if (load) begin
        oMESS      <= cmd_q[MESS_W-1:0];
        oIS_SERVER <= cmd_q[MESS_W +: ROLE_W];
      end
      // One increment per cycle no matter how many error sources fired.
      if (err && (oERR_CNT != 8'hFF)) oERR_CNT <= oERR_CNT + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    gap_nxt   = '0;
    load      = 1'b0;
    err       = 1'b0;
    if (rx_ferr) begin
      err       = 1'b1;
      state_nxt = S_IDLE;
    end else if (rx_valid) begin
      // A byte arriving clears the gap counter, even on the timeout cycle.
      case (state)
        S_IDLE: if (rx_byte == FRAME_SOF) state_nxt = S_CMD;
        S_CMD: begin
          // A repeated SOF re-synchronises rather than being taken as CMD.
          if (rx_byte != FRAME_SOF) begin
            cmd_nxt   = rx_byte;
            state_nxt = S_CHK;
          end
        end
        S_CHK: begin
          if (frame_cmd_ok(cmd_q, rx_byte)) load = 1'b1;
          else err = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE) begin
      if (gap_cnt == GAP_LAST) begin
        err       = 1'b1;
        state_nxt = S_IDLE;
      end else begin
        gap_nxt = gap_cnt + GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lcd_status_decoder.sv
// Purpose: self-checking bench for lcd_status_decoder with a byte-level reference model.
// Latency: checks oUPDATE lands inside the stop bit of the CHK byte.
// Backpressure: n/a.
module tb_lcd_status_decoder;

  localparam int CLK_HZ  = 1000000;
  localparam int BAUD    = 125000;
  localparam int CPB     = CLK_HZ / BAUD;
  localparam int TIMEOUT = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [2:0] mess;
  logic [1:0] role;
  logic       upd;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  lcd_status_decoder #(
    .CLK_HZ         (CLK_HZ),
    .BAUD           (BAUD),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iRXD       (rxd),
    .oMESS      (mess),
    .oIS_SERVER (role),
    .oUPDATE    (upd),
    .oERR_CNT   (err_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: a frame is the list of bytes collected since SOF.
  logic [7:0] mq[$];
  int exp_mess = 0, exp_role = 0, exp_err = 0, exp_upd = 0;

  function automatic void m_err();
    if (exp_err < 255) exp_err++;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    logic [7:0] c;
    if (mq.size() == 0) begin
      if (b == 8'hA5) mq.push_back(b);
    end else if (mq.size() == 1) begin
      if (b != 8'hA5) mq.push_back(b);
    end else begin
      c = mq[1];
      if ((b == (c ^ 8'hA5)) && (c < 8'd32)) begin
        exp_mess = c % 8;
        exp_role = (c / 8) % 4;
        exp_upd++;
      end else begin
        m_err();
      end
      mq.delete();
    end
  endfunction

  function automatic void m_ferr();
    m_err();
    mq.delete();
  endfunction

  function automatic void m_timeout();
    if (mq.size() != 0) begin
      m_err();
      mq.delete();
    end
  endfunction

  function automatic void m_reset();
    exp_mess = 0;
    exp_role = 0;
    exp_err  = 0;
    mq.delete();
  endfunction

  // Cycle counter and oUPDATE monitor.
  int   cyc = 0;
  int   upd_cnt = 0;
  int   last_start = 0;
  logic upd_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (upd === 1'b1) begin
      upd_cnt++;
      check("upd_single_cycle", {31'd0, upd_prev}, 32'd0);
      check("upd_in_chk_stop_bit",
            {31'd0, ((cyc - last_start) >= 9 * CPB) && ((cyc - last_start) <= 10 * CPB + 4)}, 32'd1);
    end
    upd_prev = upd;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    last_start = cyc;
    rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(CPB);
    end
    rxd = stop_bit;
    wait_cyc(CPB);
    rxd = 1'b1;
    wait_cyc(2);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_byte(b, 1'b1);
    m_byte(b);
  endtask

  task automatic send_ferr(input logic [7:0] b);
    send_byte(b, 1'b0);
    m_ferr();
    wait_cyc(CPB);
  endtask

  task automatic idle_gap(input int n);
    wait_cyc(n);
    if (n > TIMEOUT) m_timeout();
  endtask

  task automatic do_reset();
    rxd = 1'b1;
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    m_reset();
    wait_cyc(2);
  endtask

  task automatic check_outputs(input string tag);
    @(negedge clk);
    check({tag, "_mess"}, {29'd0, mess}, exp_mess);
    check({tag, "_role"}, {30'd0, role}, exp_role);
    check({tag, "_errcnt"}, {24'd0, err_cnt}, exp_err);
    check({tag, "_updates"}, upd_cnt, exp_upd);
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] cmd, chk;
    int kind;

    // Reset state.
    rst = 1'b1;
    wait_cyc(4);
    check_outputs("reset");
    check("reset_upd", {31'd0, upd}, 32'd0);
    rst = 1'b0;
    wait_cyc(4);

    // Valid frame.
    send_good(8'hA5); send_good(8'h0B); send_good(8'hAE);
    check_outputs("valid_0B");

    // Bad checksum after reset.
    do_reset();
    send_good(8'hA5); send_good(8'h0B); send_good(8'h00);
    check_outputs("bad_chk");

    // Reserved bit set, then resync on a doubled SOF.
    do_reset();
    send_good(8'hA5); send_good(8'h2B); send_good(8'h8E);
    check_outputs("rsvd_bit");
    send_good(8'hA5); send_good(8'hA5); send_good(8'h07); send_good(8'hA2);
    check_outputs("resync");

    // Inter-byte timeout; trailing bytes land in idle.
    do_reset();
    send_good(8'hA5);
    idle_gap(TIMEOUT + 200);
    send_good(8'h0B); send_good(8'hAE);
    check_outputs("timeout");

    // Framing error mid-frame, then a clean frame.
    do_reset();
    send_good(8'hA5);
    send_ferr(8'h0B);
    check_outputs("ferr");
    send_good(8'hA5); send_good(8'h12); send_good(8'hB7);
    check_outputs("after_ferr");

    // Reset in the middle of the CMD byte.
    send_good(8'hA5);
    @(posedge clk); #1;
    rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      wait_cyc(CPB);
    end
    rst = 1'b1;
    rxd = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    m_reset();
    wait_cyc(12 * CPB);
    check_outputs("mid_reset");
    send_good(8'hA5); send_good(8'h0B); send_good(8'hAE);
    check_outputs("post_reset");

    // Randomised traffic.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        cmd = 8'($urandom);
        if ($urandom_range(0, 2) != 0) cmd[7:5] = 3'd0;
        chk = ($urandom_range(0, 3) != 0) ? (cmd ^ 8'hA5) : 8'($urandom);
        fr.delete();
        if ($urandom_range(0, 4) == 0) fr.push_back(8'($urandom));
        fr.push_back(8'hA5);
        if ($urandom_range(0, 4) == 0) fr.push_back(8'hA5);
        fr.push_back(cmd);
        fr.push_back(chk);
        foreach (fr[k]) begin
          send_good(fr[k]);
          wait_cyc($urandom_range(0, 40));
        end
      end else if (kind <= 7) begin
        send_ferr(8'($urandom));
      end else if (kind == 8) begin
        // Short low glitch: must be dropped as a false start.
        @(posedge clk); #1;
        rxd = 1'b0;
        wait_cyc($urandom_range(1, 2));
        rxd = 1'b1;
        wait_cyc(2 * CPB);
      end else begin
        idle_gap(TIMEOUT + $urandom_range(100, 300));
      end
      check_outputs("rnd");
    end

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 258; i++) send_ferr(8'h55);
    check_outputs("saturate");
    send_good(8'hA5); send_good(8'h0B); send_good(8'h01);
    check_outputs("saturate_hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_status_decoder.md
Name: lcd_status_decoder

Overview:
- Upstream feeder for the LCD message stage.
- Receives 8N1 UART frames on the serial RX line and decodes 3-byte status commands.
- Drives the 3-bit message select and 2-bit role select that the LCD message stage consumes.
- Replaces the static switch inputs with values set by the remote UART peer; outputs hold between commands.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, 434 at default).
- TIMEOUT_CYCLES, 500000, maximum idle gap between bytes of one frame (10 ms at 50 MHz).

Ports:
- iCLK  in  1  system clock, 50 MHz.
- iRST  in  1  synchronous reset, active-high.
- iRXD  in  1  asynchronous UART RX line, idle high.
- oMESS  out  3  message select to LCD message stage.
- oIS_SERVER  out  2  role select to LCD message stage.
- oUPDATE  out  1  one-cycle pulse when oMESS/oIS_SERVER are loaded.
- oERR_CNT  out  8  saturating count of rejected frames and framing errors.

Behaviour:
- Reset values: oMESS=0, oIS_SERVER=0, oUPDATE=0, oERR_CNT=0, FSM=S_IDLE, RX=idle.
- Reset mid-byte or mid-frame aborts everything; no partial frame survives.
- RX front end:
  - iRXD passes through a 2-flop synchronizer.
  - Start is detected on a falling edge; the start bit is re-checked at CLKS_PER_BIT/2.
  - If low, 8 data bits (LSB first) are sampled at bit centres, then the stop bit.
  - Stop=1: rx_valid pulses 1 cycle with rx_byte.
  - Stop=0: no rx_valid; rx_ferr pulses 1 cycle.
  - A false start (high at mid-start) returns to idle silently.
- Frame format: 0xA5, CMD, CHK, where CHK = 0xA5 XOR CMD.
  - CMD[2:0] = message; CMD[4:3] = role; CMD[7:5] must be 0.
- FSM:
  - S_IDLE: rx_valid with 0xA5 -> S_CMD; any other byte is ignored (no error).
  - S_CMD:
    - rx_valid with 0xA5 -> stay in S_CMD (resync, no error).
    - Otherwise latch CMD -> S_CHK.
  - S_CHK: on rx_valid, check CHK==0xA5^CMD and CMD[7:5]==0.
    - Pass: oMESS<=CMD[2:0], oIS_SERVER<=CMD[4:3], oUPDATE=1 on the next cycle.
    - Fail: oERR_CNT+1.
    - Either way -> S_IDLE.
- Latency: outputs change, and oUPDATE is high, exactly 1 cycle after the rx_valid of the CHK byte.
- Timeout:
  - The gap counter runs in S_CMD/S_CHK and clears on every rx_valid.
  - Reaching TIMEOUT_CYCLES -> S_IDLE, oERR_CNT+1.
  - If rx_valid and timeout occur in the same cycle, the byte wins and the counter clears.
- Framing error:
  - rx_ferr in any state -> oERR_CNT+1.
  - If in S_CMD/S_CHK, also -> S_IDLE.
- oERR_CNT saturates at 255; it is cleared only by reset.
- Two error sources in one cycle increment the count once.

Decomposition:
- Shared package lcd_uart_pkg:
  - Constants: FRAME_SOF=8'hA5, CMD_RSVD_MSB=7, CMD_RSVD_LSB=5.
  - State encoding: S_IDLE, S_CMD, S_CHK.
  - MESS_W=3, ROLE_W=2.
- One sub-module, uart_rx_byte: synchronizer, bit timer, shift register; produces rx_valid/rx_byte/rx_ferr. The frame FSM, timeout and error counter live in lcd_status_decoder.

Test Plan:
- Send A5 0B AE at 115200 -> oUPDATE pulses once, oMESS=3, oIS_SERVER=1, oERR_CNT=0.
- Send A5 0B 00 (bad checksum) -> outputs unchanged from reset (0,0), no oUPDATE, oERR_CNT=1.
- Send A5 2B 8E (reserved bit set, valid checksum) -> rejected, oERR_CNT=1; then A5 A5 07 A2 -> resync, oMESS=7, oIS_SERVER=0.
- Send A5, idle 600000 cycles, then 0B AE -> timeout, oERR_CNT=1, no update; the trailing bytes are ignored in S_IDLE.
- Send a byte with stop bit forced 0 mid-frame after A5 -> oERR_CNT=1, FSM in S_IDLE; the next full A5 12 B7 gives oMESS=2, oIS_SERVER=2.
- Assert iRST during the CMD byte of A5 0B AE -> all outputs 0 after reset, no oUPDATE; the next valid frame decodes normally.
